demux_frame_sequencer: RTL
==========================

DEMUX_FRAME_SEQUENCER -- requirements
Module: demux_frame_sequencer

Interface
REQ-001 Parameter: FRAME_LEN, default 32, number of bits per frame; legal range 1..32.
REQ-002 Parameter: SEL_W, default 5, width of the DEMUX select bus.
REQ-003 Clock_In  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset_In  input  1  asynchronous, active-low reset.
REQ-005 Serial_Data_In  input  1  serial payload bit.
REQ-006 Serial_Valid_In  input  1  Serial_Data_In is valid this cycle.
REQ-007 Serial_Ready_Out  output  1  block accepts a bit this cycle.
REQ-008 Abort_In  input  1  synchronous frame abort.
REQ-009 Demux_Enable_Out  output  1  drives the 1:32 DEMUX enable.
REQ-010 Demux_Data_Out  output  1  drives the DEMUX data input.
REQ-011 Demux_Select_Out  output  SEL_W  drives the DEMUX select.
REQ-012 Demux_Lines_In  input  32  the 32 DEMUX outputs, fed back in; Z when the DEMUX is disabled.
REQ-013 Frame_Data_Out  output  32  assembled frame; bit i = i-th accepted bit.
REQ-014 Frame_Valid_Out  output  1  Frame_Data_Out is complete and stable.
REQ-015 Frame_Ready_In  input  1  consumer takes the frame.
REQ-016 Frame_Count_Out  output  8  count of delivered frames; wraps 255->0.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, DRAIN and HOLD, with an internal bit index idx (0..FRAME_LEN-1).
REQ-018 Serial_Ready_Out SHALL be 1 in IDLE and SHIFT and 0 in DRAIN and HOLD; it SHALL also be 0 while Abort_In=1.
REQ-019 Accept: Serial_Valid_In & Serial_Ready_Out at an edge SHALL register Demux_Data_Out<=Serial_Data_In, Demux_Select_Out<=idx and Demux_Enable_Out<=1.
REQ-020 In a cycle with no accept, Demux_Enable_Out SHALL be 0; Demux_Select_Out and Demux_Data_Out SHALL hold their values.
REQ-021 At every edge where Demux_Enable_Out=1, the block SHALL capture Frame_Data_Out[Demux_Select_Out] <= Demux_Lines_In[Demux_Select_Out].
REQ-022 Demux_Lines_In SHALL never be sampled while Demux_Enable_Out=0 (lines are Z).
REQ-023 Transitions: IDLE->SHIFT on the first accept (idx becomes 1); SHIFT->SHIFT on an accept with idx<FRAME_LEN-1 (idx increments); an accept at idx=FRAME_LEN-1 SHALL go to DRAIN with idx<=0.
REQ-024 If FRAME_LEN=1, an accept in IDLE SHALL go directly to DRAIN.
REQ-025 DRAIN->HOLD after one cycle, which captures the last bit; Frame_Valid_Out SHALL be 1 in HOLD only.
REQ-026 Latency: with the last bit accepted at edge t, Frame_Valid_Out SHALL be 1 from edge t+2.
REQ-027 In HOLD, Frame_Data_Out SHALL be stable until the handshake; Frame_Valid_Out & Frame_Ready_In SHALL go to IDLE, increment Frame_Count_Out and clear Frame_Data_Out to 0.
REQ-028 Bits not yet accepted in the current frame SHALL read 0 in Frame_Data_Out; bits at index >= FRAME_LEN SHALL always be 0.
REQ-029 Gaps where Serial_Valid_In=0 in SHIFT SHALL leave idx and the partial frame unchanged.
REQ-030 Abort_In=1 in any state SHALL, at the next edge, go to IDLE with idx=0, Frame_Data_Out=0, Frame_Valid_Out=0 and Demux_Enable_Out=0; Frame_Count_Out SHALL be unchanged.
REQ-031 Abort_In SHALL take priority over a simultaneous accept or frame handshake.

Reset
REQ-032 While Reset_In=0, the block SHALL immediately enter IDLE with idx=0 and all outputs 0 (Serial_Ready_Out 1 only after release), including Frame_Count_Out=0.
REQ-033 Reset asserted mid-frame or in HOLD SHALL discard the frame without incrementing the counter.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the frame width constant (32) and the default SEL_W.
REQ-035 The frame capture register SHALL be a single sub-module, frame_capture_reg (indexed write, clear, hold).

Verification
REQ-036 Send bits 1,0,1,1 then 28 zeros with FRAME_LEN=32 and Valid held high -> Frame_Data_Out=32'h0000000D, valid at edge t+2 after the last accept, Frame_Count_Out=1.
REQ-037 Hold Frame_Ready_In=0 for 10 cycles in HOLD -> Serial_Ready_Out=0, data stable for all 10 cycles; at the handshake Frame_Count_Out increments by 1 and the block returns to IDLE.
REQ-038 Drive random Valid gaps across a 0xA5A5A5A5 stream -> identical frame; Demux_Enable_Out=0 on every gap cycle.
REQ-039 Assert Abort_In at bit 17 together with a valid bit -> no accept, outputs cleared next edge, counter unchanged; the next full frame is correct.
REQ-040 Use FRAME_LEN=1 with bit 1 -> Frame_Data_Out=32'h00000001, valid 2 cycles after the accept.
REQ-041 Pulse Reset_In low in HOLD asynchronously (mid-cycle) -> all outputs 0 immediately, Frame_Count_Out=0.

Source files
------------

// File: rtl/demux_frame_sequencer_pkg.sv
// Shared types and constants for the DEMUX frame sequencer and its capture register.
package demux_frame_sequencer_pkg;

  localparam int FRAME_W       = 32;
  localparam int SEL_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/frame_capture_reg.sv
// Frame assembly register: one indexed bit write per cycle from the DEMUX feedback lines, plus clear and hold.
module frame_capture_reg
  import demux_frame_sequencer_pkg::*;
#(
  parameter int FRAME_LEN = 32,
  parameter int SEL_W     = SEL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               wr_en_i,
  input  logic [SEL_W-1:0]   wr_idx_i,
  input  logic [FRAME_W-1:0] lines_i,
  output logic [FRAME_W-1:0] data_o
);

  logic [FRAME_W-1:0] data_q, data_d;

  // Lines are only looked at while the DEMUX is enabled; otherwise they float.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (wr_en_i && (int'(wr_idx_i) < FRAME_LEN)) begin
      data_d[wr_idx_i] = lines_i[wr_idx_i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/demux_frame_sequencer.sv
// Serial-to-parallel frame sequencer that steers each bit through an external 1:32 DEMUX
// and reassembles the frame from the DEMUX outputs fed back in.
module demux_frame_sequencer
  import demux_frame_sequencer_pkg::*;
#(
  parameter int FRAME_LEN = 32,
  parameter int SEL_W     = SEL_W_DEFAULT
) (
  input  logic               Clock_In,
  input  logic               Reset_In,
  input  logic               Serial_Data_In,
  input  logic               Serial_Valid_In,
  output logic               Serial_Ready_Out,
  input  logic               Abort_In,
  output logic               Demux_Enable_Out,
  output logic               Demux_Data_Out,
  output logic [SEL_W-1:0]   Demux_Select_Out,
  input  logic [FRAME_W-1:0] Demux_Lines_In,
  output logic [FRAME_W-1:0] Frame_Data_Out,
  output logic               Frame_Valid_Out,
  input  logic               Frame_Ready_In,
  output logic [7:0]         Frame_Count_Out
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             en_q, en_d;
  logic             dat_q, dat_d;
  logic             frame_valid_q, frame_valid_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             accept;
  logic             handshake;
  logic             frame_clr;

  assign accept    = Serial_Valid_In & Serial_Ready_Out;
  assign handshake = frame_valid_q & Frame_Ready_In;
  assign frame_clr = Abort_In | handshake;

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (Abort_In) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_SHIFT: begin
          if (accept) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_DRAIN;
              idx_d   = '0;
            end else begin
              state_d = ST_SHIFT;
              idx_d   = idx_q + 1'b1;
            end
          end
        end
        ST_DRAIN: state_d = ST_HOLD;
        ST_HOLD:  if (handshake) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Ready is forced low during reset so nothing is offered before release.
  always_comb begin
    Serial_Ready_Out = Reset_In & ~Abort_In &
                       ((state_q == ST_IDLE) | (state_q == ST_SHIFT));
  end

  // Valid trails HOLD entry by one cycle so the frame is exposed two edges after the last accept.
  always_comb begin
    en_d          = accept;
    sel_d         = accept ? idx_q : sel_q;
    dat_d         = accept ? Serial_Data_In : dat_q;
    frame_valid_d = ~Abort_In & (state_q == ST_HOLD) & ~handshake;
    cnt_d         = (handshake & ~Abort_In) ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      en_q          <= 1'b0;
      sel_q         <= '0;
      dat_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      en_q          <= en_d;
      sel_q         <= sel_d;
      dat_q         <= dat_d;
      frame_valid_q <= frame_valid_d;
      cnt_q         <= cnt_d;
    end
  end

  frame_capture_reg #(
    .FRAME_LEN (FRAME_LEN),
    .SEL_W     (SEL_W)
  ) u_capture (
    .clk      (Clock_In),
    .rst_n    (Reset_In),
    .clr_i    (frame_clr),
    .wr_en_i  (en_q),
    .wr_idx_i (sel_q),
    .lines_i  (Demux_Lines_In),
    .data_o   (Frame_Data_Out)
  );

  assign Demux_Enable_Out = en_q;
  assign Demux_Select_Out = sel_q;
  assign Demux_Data_Out   = dat_q;
  assign Frame_Valid_Out  = frame_valid_q;
  assign Frame_Count_Out  = cnt_q;

endmodule
